// File: rtl/pipeline_pkg.sv
// Shared types for the hazard/forwarding control block: shadow stage record,
// forward-select encoding, control-action enum and small helpers.
package pipeline_pkg;

  localparam int REG_W = 5;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  // One shadow pipeline stage: just enough of the instruction to detect hazards.
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] ra;
    logic [REG_W-1:0] rb;
    logic [REG_W-1:0] rd;
    logic             regwr;
    logic             memtoreg;
  } stage_rec_t;

  localparam stage_rec_t BUBBLE = '0;

  typedef enum logic [1:0] {
    CTL_RUN,
    CTL_STALL,
    CTL_REDIRECT,
    CTL_RESET
  } ctl_e;

  // A stage can supply a result only if it really writes a non-zero register.
  function automatic logic writes_reg(input stage_rec_t rec);
    return rec.valid & rec.regwr & (rec.rd != '0);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fwd_sel.sv
// Forward-source selection for one EX operand: EX/M result wins over M/WB,
// otherwise the register file value is used.
module fwd_sel
  import pipeline_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic             mem_ok,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             wb_ok,
  input  logic [REG_W-1:0] wb_rd,
  output fwd_sel_e         sel
);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    sel = FWD_RF;
    if (mem_ok && (mem_rd == src)) begin
      sel = FWD_MEM;
    end else if (wb_ok && (wb_rd == src)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: shadow EX/M/WB records, load-use stall, M-stage
// redirect flush, operand forwarding selects and saturating event counters.
module hazard_ctrl
  import pipeline_pkg::*;
(
  input  logic             Clk,
  input  logic             Resetn,
  input  logic             IdValid,
  input  logic [REG_W-1:0] IdRa,
  input  logic [REG_W-1:0] IdRb,
  input  logic [REG_W-1:0] IdRd,
  input  logic             IdUsesRa,
  input  logic             IdUsesRb,
  input  logic             IdRegWr,
  input  logic             IdMemtoReg,
  input  logic             RedirectM,
  output logic             PCWr,
  output logic             IFIDWr,
  output logic             IFIDFlush,
  output logic             IDEXFlush,
  output logic             EXMFlush,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  stage_rec_t ex_q, m_q, wb_q;
  stage_rec_t id_rec;
  logic       load_use;
  logic       mem_ok;
  logic       wb_ok;
  ctl_e       ctl;
  fwd_sel_e   fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  assign id_rec = '{valid: IdValid, ra: IdRa, rb: IdRb, rd: IdRd,
                    regwr: IdRegWr, memtoreg: IdMemtoReg};

  // A load in EX cannot be forwarded to the instruction behind it yet.
  assign load_use = IdValid & ex_q.valid & ex_q.memtoreg & ex_q.regwr &
                    (ex_q.rd != '0) &
                    ((IdUsesRa & (IdRa == ex_q.rd)) | (IdUsesRb & (IdRb == ex_q.rd)));

  always_comb begin
    ctl = CTL_RUN;
    if (!Resetn) begin
      ctl = CTL_RESET;
    end else if (RedirectM) begin
      ctl = CTL_REDIRECT;
    end else if (load_use) begin
      ctl = CTL_STALL;
    end
  end

  always_comb begin
    PCWr      = 1'b1;
    IFIDWr    = 1'b1;
    IFIDFlush = 1'b0;
    IDEXFlush = 1'b0;
    EXMFlush  = 1'b0;
    unique case (ctl)
      CTL_RUN: ;
      CTL_STALL: begin
        PCWr      = 1'b0;
        IFIDWr    = 1'b0;
        IDEXFlush = 1'b1;
      end
      CTL_REDIRECT: begin
        IFIDFlush = 1'b1;
        IDEXFlush = 1'b1;
        EXMFlush  = 1'b1;
      end
      CTL_RESET: begin
        PCWr      = 1'b0;
        IFIDWr    = 1'b0;
        IFIDFlush = 1'b1;
        IDEXFlush = 1'b1;
        EXMFlush  = 1'b1;
      end
      default: ;
    endcase
  end

  // Source qualification is shared by both operands; a load in M has no data yet.
  assign mem_ok = writes_reg(m_q) & ~m_q.memtoreg;
  assign wb_ok  = writes_reg(wb_q);

  fwd_sel u_fwd_a (
    .src    (ex_q.ra),
    .mem_ok (mem_ok),
    .mem_rd (m_q.rd),
    .wb_ok  (wb_ok),
    .wb_rd  (wb_q.rd),
    .sel    (fwd_a)
  );

  fwd_sel u_fwd_b (
    .src    (ex_q.rb),
    .mem_ok (mem_ok),
    .mem_rd (m_q.rd),
    .wb_ok  (wb_ok),
    .wb_rd  (wb_q.rd),
    .sel    (fwd_b)
  );

  assign ForwardA = Resetn ? fwd_a : FWD_RF;
  assign ForwardB = Resetn ? fwd_b : FWD_RF;

  // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      ex_q        <= BUBBLE;
      m_q         <= BUBBLE;
      wb_q        <= BUBBLE;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q <= IDEXFlush ? BUBBLE : id_rec;
      m_q  <= RedirectM ? BUBBLE : ex_q;
      wb_q <= m_q;
      if (ctl == CTL_STALL) begin
        stall_cnt_q <= sat_inc(stall_cnt_q);
      end
      if (RedirectM) begin
        flush_cnt_q <= sat_inc(flush_cnt_q);
      end
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;

  // Fields carried for pipeline fidelity that no downstream check reads.
  logic unused_fields;
  assign unused_fields = ^{m_q.ra, m_q.rb, wb_q.ra, wb_q.rb, wb_q.memtoreg};

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a cycle-by-cycle vector table plus
// hand-written sequences for Rb stall, redirect, counter saturation and reset.
module tb_hazard_ctrl;

  logic        clk;
  logic        resetn;
  logic        id_valid;
  logic [4:0]  id_ra, id_rb, id_rd;
  logic        id_uses_ra, id_uses_rb, id_regwr, id_memtoreg;
  logic        redirect_m;
  logic        pc_wr, ifid_wr, ifid_flush, idex_flush, exm_flush;
  logic [1:0]  forward_a, forward_b;
  logic [15:0] stall_cnt, flush_cnt;

  int tests = 0;
  int fails = 0;

  localparam logic [4:0] C_RUN   = 5'b11000;
  localparam logic [4:0] C_STALL = 5'b00010;
  localparam logic [4:0] C_REDIR = 5'b11111;
  localparam logic [4:0] C_RESET = 5'b00111;

  hazard_ctrl dut (
    .Clk        (clk),
    .Resetn     (resetn),
    .IdValid    (id_valid),
    .IdRa       (id_ra),
    .IdRb       (id_rb),
    .IdRd       (id_rd),
    .IdUsesRa   (id_uses_ra),
    .IdUsesRb   (id_uses_rb),
    .IdRegWr    (id_regwr),
    .IdMemtoReg (id_memtoreg),
    .RedirectM  (redirect_m),
    .PCWr       (pc_wr),
    .IFIDWr     (ifid_wr),
    .IFIDFlush  (ifid_flush),
    .IDEXFlush  (idex_flush),
    .EXMFlush   (exm_flush),
    .ForwardA   (forward_a),
    .ForwardB   (forward_b),
    .StallCnt   (stall_cnt),
    .FlushCnt   (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    logic [4:0]  ra, rb, rd;
    bit          ua, ub, wr, mt, rdr;
    logic [4:0]  ctl;
    logic [1:0]  fa, fb;
    logic [15:0] sc, fc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input bit v, input int ra, input int rb, input int rd,
                              input bit ua, input bit ub, input bit wr, input bit mt,
                              input bit rdr, input logic [4:0] ctl,
                              input logic [1:0] fa, input logic [1:0] fb,
                              input int sc, input int fc);
    vec_t r;
    r.v = v; r.ra = 5'(ra); r.rb = 5'(rb); r.rd = 5'(rd);
    r.ua = ua; r.ub = ub; r.wr = wr; r.mt = mt; r.rdr = rdr;
    r.ctl = ctl; r.fa = fa; r.fb = fb; r.sc = 16'(sc); r.fc = 16'(fc);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_id(input bit v, input int ra, input int rb, input int rd,
                          input bit ua, input bit ub, input bit wr, input bit mt);
    id_valid    = v;
    id_ra       = 5'(ra);
    id_rb       = 5'(rb);
    id_rd       = 5'(rd);
    id_uses_ra  = ua;
    id_uses_rb  = ub;
    id_regwr    = wr;
    id_memtoreg = mt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] ctl_now();
    return {pc_wr, ifid_wr, ifid_flush, idex_flush, exm_flush};
  endfunction

  initial begin
    // Each row is one cycle; expected outputs follow from the rows before it.
    //        v ra rb rd ua ub wr mt rdr  ctl      fa     fb    sc fc
    vecs.push_back(mk(1, 1, 0, 5, 1, 0, 1, 1, 0, C_RUN,   2'b00, 2'b00, 0, 0)); // lw x5
    vecs.push_back(mk(1, 5, 7, 6, 1, 1, 1, 0, 0, C_STALL, 2'b00, 2'b00, 0, 0)); // add x6,x5,x7
    vecs.push_back(mk(1, 5, 7, 6, 1, 1, 1, 0, 0, C_RUN,   2'b00, 2'b00, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN,   2'b01, 2'b00, 1, 0)); // lw reaches WB
    vecs.push_back(mk(1, 1, 2, 3, 1, 1, 1, 0, 0, C_RUN,   2'b00, 2'b00, 1, 0)); // add x3
    vecs.push_back(mk(1, 1, 2, 3, 1, 1, 1, 0, 0, C_RUN,   2'b00, 2'b00, 1, 0)); // add x3
    vecs.push_back(mk(1, 3, 9, 8, 1, 1, 1, 0, 0, C_RUN,   2'b00, 2'b00, 1, 0)); // add x8,x3,x9
    vecs.push_back(mk(1, 1, 2, 3, 1, 1, 1, 0, 0, C_RUN,   2'b10, 2'b00, 1, 0)); // M wins over WB
    vecs.push_back(mk(1, 1, 2, 4, 1, 1, 1, 0, 0, C_RUN,   2'b00, 2'b00, 1, 0)); // add x4
    vecs.push_back(mk(1, 3, 4, 12,1, 1, 1, 0, 0, C_RUN,   2'b00, 2'b00, 1, 0)); // add x12,x3,x4
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 1, 1, 0, C_RUN,   2'b01, 2'b10, 1, 0)); // lw x0
    vecs.push_back(mk(1, 0, 0, 6, 1, 1, 1, 0, 0, C_RUN,   2'b00, 2'b00, 1, 0)); // reads x0: no stall
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN,   2'b00, 2'b00, 1, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 1, 0, 0, C_RUN,   2'b00, 2'b00, 1, 0)); // WB writes x0
    vecs.push_back(mk(1, 0, 0, 7, 1, 1, 1, 0, 0, C_RUN,   2'b00, 2'b00, 1, 0));
    vecs.push_back(mk(1, 1, 0, 9, 1, 0, 1, 1, 0, C_RUN,   2'b00, 2'b00, 1, 0)); // M writes x0
    vecs.push_back(mk(1, 9, 9, 10,0, 0, 1, 0, 0, C_RUN,   2'b00, 2'b00, 1, 0)); // unused sources
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN,   2'b00, 2'b00, 1, 0)); // load in M not fwd

    // Reset
    resetn = 1'b0;
    redirect_m = 1'b0;
    drive_id(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    check("reset ctl", 32'(ctl_now()), 32'(C_RESET));
    check("reset fwd", {28'd0, forward_a, forward_b}, 32'd0);
    tick();
    check("reset cnt", {stall_cnt, flush_cnt}, 32'd0);
    resetn = 1'b1;
    #2;
    check("post-reset ctl", 32'(ctl_now()), 32'(C_RUN));
    check("post-reset fwd", {28'd0, forward_a, forward_b}, 32'd0);
    tick();

    // Vector table
    for (int i = 0; i < vecs.size(); i++) begin
      drive_id(vecs[i].v, int'(vecs[i].ra), int'(vecs[i].rb), int'(vecs[i].rd),
               vecs[i].ua, vecs[i].ub, vecs[i].wr, vecs[i].mt);
      redirect_m = vecs[i].rdr;
      #2;
      check($sformatf("row%0d ctl", i), 32'(ctl_now()), 32'(vecs[i].ctl));
      check($sformatf("row%0d fwd_a", i), 32'(forward_a), 32'(vecs[i].fa));
      check($sformatf("row%0d fwd_b", i), 32'(forward_b), 32'(vecs[i].fb));
      check($sformatf("row%0d stall_cnt", i), 32'(stall_cnt), 32'(vecs[i].sc));
      check($sformatf("row%0d flush_cnt", i), 32'(flush_cnt), 32'(vecs[i].fc));
      tick();
    end

    // Load-use through Rb only, exactly one stall cycle, then WB forward on B
    drive_id(1, 1, 0, 5, 1, 0, 1, 1);
    #2; check("rb lw ctl", 32'(ctl_now()), 32'(C_RUN));
    tick();
    drive_id(1, 7, 5, 6, 1, 1, 1, 0);
    #2; check("rb stall ctl", 32'(ctl_now()), 32'(C_STALL));
    check("rb stall cnt before", 32'(stall_cnt), 32'd1);
    tick();
    #2; check("rb one-cycle ctl", 32'(ctl_now()), 32'(C_RUN));
    check("rb stall cnt after", 32'(stall_cnt), 32'd2);
    tick();
    drive_id(0, 0, 0, 0, 0, 0, 0, 0);
    #2; check("rb fwd_b wb", 32'(forward_b), 32'(2'b01));
    check("rb fwd_a none", 32'(forward_a), 32'(2'b00));
    tick();

    // Redirect coincident with load-use: redirect wins, M is killed
    drive_id(1, 1, 0, 5, 1, 0, 1, 1);
    #2; check("redir lw ctl", 32'(ctl_now()), 32'(C_RUN));
    tick();
    drive_id(1, 5, 5, 6, 1, 1, 1, 0);
    redirect_m = 1'b1;
    #2; check("redir ctl", 32'(ctl_now()), 32'(C_REDIR));
    tick();
    redirect_m = 1'b0;
    drive_id(1, 5, 0, 8, 1, 0, 1, 0);
    #2; check("redir after ctl", 32'(ctl_now()), 32'(C_RUN));
    check("redir stall cnt held", 32'(stall_cnt), 32'd2);
    check("redir flush cnt", 32'(flush_cnt), 32'd1);
    tick();
    drive_id(0, 0, 0, 0, 0, 0, 0, 0);
    #2; check("redir killed M no fwd", 32'(forward_a), 32'(2'b00));
    tick();

    // Flush counter saturation
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    #2; check("sat start cnt", {stall_cnt, flush_cnt}, 32'd0);
    redirect_m = 1'b1;
    repeat (65534) tick();
    redirect_m = 1'b0;
    #2; check("sat preload", 32'(flush_cnt), 32'h0000_FFFE);
    redirect_m = 1'b1;
    tick();
    tick();
    redirect_m = 1'b0;
    #2; check("sat hold", 32'(flush_cnt), 32'h0000_FFFF);
    check("sat stall cnt", 32'(stall_cnt), 32'd0);
    tick();

    // Reset during a stall with a live M forward
    drive_id(1, 1, 1, 2, 1, 1, 1, 0);
    tick();
    drive_id(1, 2, 0, 5, 1, 0, 1, 1);
    #2; check("rst-stall setup ctl", 32'(ctl_now()), 32'(C_RUN));
    tick();
    drive_id(1, 5, 0, 6, 1, 0, 1, 0);
    #2; check("rst-stall stall ctl", 32'(ctl_now()), 32'(C_STALL));
    check("rst-stall fwd_a mem", 32'(forward_a), 32'(2'b10));
    resetn = 1'b0;
    #2; check("rst-stall reset ctl", 32'(ctl_now()), 32'(C_RESET));
    check("rst-stall reset fwd", {28'd0, forward_a, forward_b}, 32'd0);
    tick();
    resetn = 1'b1;
    #2; check("rst-stall release ctl", 32'(ctl_now()), 32'(C_RUN));
    check("rst-stall release fwd", {28'd0, forward_a, forward_b}, 32'd0);
    check("rst-stall release cnt", {stall_cnt, flush_cnt}, 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
